// File: rtl/jtroadf_romarb.sv
// rtl/jtroadf_romarb.sv - three-way ROM arbiter with one-word hit caches onto a shared SDRAM read bank
module jtroadf_romarb #(
  parameter int          MAIN_AW     = 16,
  parameter int          SND_AW      = 13,
  parameter int          PCM_AW      = 16,
  parameter logic [21:0] MAIN_OFFSET = 22'h0,
  parameter logic [21:0] SND_OFFSET  = 22'h0,
  parameter logic [21:0] PCM_OFFSET  = 22'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               downloading,
  input  logic [MAIN_AW-1:0] main_addr,
  input  logic               main_cs,
  output logic [7:0]         main_data,
  output logic               main_ok,
  input  logic [SND_AW-1:0]  snd_addr,
  input  logic               snd_cs,
  output logic [7:0]         snd_data,
  output logic               snd_ok,
  input  logic [PCM_AW-1:0]  pcm_addr,
  input  logic               pcm_cs,
  output logic [7:0]         pcm_data,
  output logic               pcm_ok,
  output logic [21:0]        sdram_addr,
  output logic               sdram_rd,
  input  logic               sdram_ack,
  input  logic               sdram_dst,
  input  logic [15:0]        sdram_din
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // widest word tag among the three requesters; the in-flight tag is held at this width
  localparam int TW0 = (MAIN_AW > SND_AW) ? MAIN_AW : SND_AW;
  localparam int TW  = ((TW0 > PCM_AW) ? TW0 : PCM_AW) - 1;

  logic [1:0]         st, rr, gnt, sel;
  logic [2:0]         valid, pend;
  logic [MAIN_AW-2:0] main_tag;
  logic [SND_AW-2:0]  snd_tag;
  logic [PCM_AW-2:0]  pcm_tag;
  logic [15:0]        main_word, snd_word, pcm_word;
  logic [TW-1:0]      lat_tag, sel_tag;
  logic [21:0]        sel_addr;
  logic               main_hit, snd_hit, pcm_hit, fill;

  assign main_hit = main_cs & valid[0] & (main_tag == main_addr[MAIN_AW-1:1]);
  assign snd_hit  = snd_cs  & valid[1] & (snd_tag  == snd_addr[SND_AW-1:1]);
  assign pcm_hit  = pcm_cs  & valid[2] & (pcm_tag  == pcm_addr[PCM_AW-1:1]);

  assign main_ok  = main_hit;
  assign snd_ok   = snd_hit;
  assign pcm_ok   = pcm_hit;

  assign main_data = main_addr[0] ? main_word[15:8] : main_word[7:0];
  assign snd_data  = snd_addr[0]  ? snd_word[15:8]  : snd_word[7:0];
  assign pcm_data  = pcm_addr[0]  ? pcm_word[15:8]  : pcm_word[7:0];

  assign pend = {pcm_cs  & ~pcm_hit  & ~downloading,
                 snd_cs  & ~snd_hit  & ~downloading,
                 main_cs & ~main_hit & ~downloading};

  // the word only lands in a cache when the bank delivers it during an active transfer
  assign fill = sdram_dst & ~downloading &
                ((st == ST_DATA) | ((st == ST_REQ) & sdram_ack));

  // round-robin pick: first pending requester at or after the pointer
  always_comb begin
    sel = 2'd0;
    case (rr)
      2'd1:    sel = pend[1] ? 2'd1 : (pend[2] ? 2'd2 : 2'd0);
      2'd2:    sel = pend[2] ? 2'd2 : (pend[0] ? 2'd0 : 2'd1);
      default: sel = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
    endcase
  end

  // word address and tag of the selected requester
  always_comb begin
    sel_tag  = TW'(main_addr[MAIN_AW-1:1]);
    sel_addr = MAIN_OFFSET + 22'(main_addr[MAIN_AW-1:1]);
    case (sel)
      2'd1: begin
        sel_tag  = TW'(snd_addr[SND_AW-1:1]);
        sel_addr = SND_OFFSET + 22'(snd_addr[SND_AW-1:1]);
      end
      2'd2: begin
        sel_tag  = TW'(pcm_addr[PCM_AW-1:1]);
        sel_addr = PCM_OFFSET + 22'(pcm_addr[PCM_AW-1:1]);
      end
      default: ;
    endcase
  end

  // transaction sequencer: grant, hold the read until accepted, wait for the word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_IDLE;
      rr         <= 2'd0;
      gnt        <= 2'd0;
      lat_tag    <= '0;
      sdram_addr <= 22'd0;
      sdram_rd   <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: if (|pend) begin
          gnt        <= sel;
          rr         <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
          lat_tag    <= sel_tag;
          sdram_addr <= sel_addr;
          sdram_rd   <= 1'b1;
          st         <= ST_REQ;
        end
        ST_REQ: if (sdram_ack) begin
          sdram_rd <= 1'b0;
          st       <= sdram_dst ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (sdram_dst) st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

  // cache fill for the granted requester; a download wipes every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= 3'b000;
      main_tag  <= '0;
      snd_tag   <= '0;
      pcm_tag   <= '0;
      main_word <= 16'd0;
      snd_word  <= 16'd0;
      pcm_word  <= 16'd0;
    end else begin
      if (fill) begin
        case (gnt)
          2'd1: begin
            snd_word <= sdram_din;
            snd_tag  <= lat_tag[SND_AW-2:0];
            valid[1] <= 1'b1;
          end
          2'd2: begin
            pcm_word <= sdram_din;
            pcm_tag  <= lat_tag[PCM_AW-2:0];
            valid[2] <= 1'b1;
          end
          default: begin
            main_word <= sdram_din;
            main_tag  <= lat_tag[MAIN_AW-2:0];
            valid[0]  <= 1'b1;
          end
        endcase
      end
      if (downloading) valid <= 3'b000;
    end
  end

endmodule
